// File: rtl/pipe_share_arb.sv
// rtl/pipe_share_arb.sv - round-robin sharing of one free-running fixed-latency datapath among NUM_REQ requesters
// Optional per-requester saturating grant counters when PIPE_ARB_STATS_EN is defined.
module pipe_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           pipe_din,
  output logic                       pipe_issue,
  input  logic [WIDTH-1:0]           pipe_dout,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       busy
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      stat_grants
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]            pipe_din_q;
  logic [IDW-1:0]              din_id_q;
  logic                        pipe_issue_q;
  logic [LATENCY-1:0]          tag_vld_q;
  logic [LATENCY-1:0][IDW-1:0] tag_id_q;

  logic                        win_found;
  logic [IDW-1:0]              win_id;
  logic [IDW:0]                scan_idx;
  logic                        xfer;
  logic [WIDTH-1:0]            win_data;

  // Scan from rr_ptr upward with wrap; scan_idx carries one extra bit so the sum never overflows.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[scan_idx[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[IDW-1:0];
      end
    end
  end

  assign xfer     = issue_en & win_found;
  assign win_data = req_data[win_id*WIDTH +: WIDTH];
  assign rr_ptr_d = (win_id == IDW'(NUM_REQ-1)) ? '0 : win_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[win_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q     <= '0;
      pipe_din_q   <= '0;
      din_id_q     <= '0;
      pipe_issue_q <= 1'b0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
    end else begin
      pipe_issue_q <= xfer;
      if (xfer) begin
        pipe_din_q <= win_data;
        din_id_q   <= win_id;
        rr_ptr_q   <= rr_ptr_d;
      end
      // Tags shift every cycle to stay aligned with the unstallable datapath.
      tag_vld_q[0] <= pipe_issue_q;
      tag_id_q[0]  <= din_id_q;
      for (int k = LATENCY-1; k > 0; k--) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_valid[tag_id_q[LATENCY-1]] = tag_vld_q[LATENCY-1];
  end

  assign pipe_din   = pipe_din_q;
  assign pipe_issue = pipe_issue_q;
  assign resp_data  = pipe_dout;
  assign busy       = pipe_issue_q | (|tag_vld_q);

`ifdef PIPE_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_q <= '0;
    end else if (xfer && grant_cnt_q[win_id] != 16'hFFFF) begin
      grant_cnt_q[win_id] <= grant_cnt_q[win_id] + 16'd1;
    end
  end

  assign stat_grants = grant_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_share_arb.sv
// tb/tb_pipe_share_arb.sv - randomized self-checking bench for pipe_share_arb against a transaction-level model
module tb_pipe_share_arb;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int L   = 4;
  localparam logic [W-1:0] KEY = 32'h5A3C_96E1;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_en;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     pipe_din;
  logic             pipe_issue;
  logic [W-1:0]     pipe_dout;
  logic [N-1:0]     resp_valid;
  logic [W-1:0]     resp_data;
  logic             busy;
`ifdef PIPE_ARB_STATS_EN
  logic [N*16-1:0]  stat_grants;
`endif

  pipe_share_arb #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .pipe_din(pipe_din),
    .pipe_issue(pipe_issue), .pipe_dout(pipe_dout), .resp_valid(resp_valid),
    .resp_data(resp_data), .busy(busy)
`ifdef PIPE_ARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  always #5 clk = ~clk;

  // Free-running datapath stand-in: a keyed XOR delayed by L cycles, never reset.
  logic [W-1:0] dp [L];
  always @(posedge clk) begin
    dp[0] <= pipe_din ^ KEY;
    for (int k = 1; k < L; k++) dp[k] <= dp[k-1];
  end
  assign pipe_dout = dp[L-1];

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] d;
  } item_t;

  item_t        q[$];
  int           rr;
  int           cyc;
  logic         prev_xfer;
  logic [W-1:0] exp_din;
  int           grants [N];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rr = 0;
    prev_xfer = 1'b0;
    exp_din = '0;
    for (int i = 0; i < N; i++) grants[i] = 0;
  endtask

  task automatic step(input logic en, input logic [N-1:0] vld, input logic [N*W-1:0] data);
    int g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    issue_en  = en;
    req_valid = vld;
    req_data  = data;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && vld[(rr + k) % N]) g = (rr + k) % N;
    end
    exp_rdy = '0;
    if (en && g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("pipe_issue", pipe_issue, prev_xfer);
    check_eq("pipe_din", pipe_din, exp_din);
    check_eq("busy", busy, q.size() != 0);
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_rv = '0;
      exp_rv[q[0].id] = 1'b1;
      check_eq("resp_valid", resp_valid, exp_rv);
      check_eq("resp_data", resp_data, q[0].d ^ KEY);
      void'(q.pop_front());
    end else begin
      check_eq("resp_idle", resp_valid, '0);
    end
    prev_xfer = (exp_rdy != '0);
    if (prev_xfer) begin
      exp_din = data[g*W +: W];
      q.push_back('{due: cyc + 1 + L, id: g, d: exp_din});
      rr = (g + 1) % N;
      grants[g]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  initial begin
    logic [N*W-1:0] d;
    rst = 1'b0;
    issue_en = 1'b0;
    req_valid = '0;
    req_data = '0;
    cyc = 0;
    model_reset();
    #12;
    check_eq("rst_pipe_issue", pipe_issue, 1'b0);
    check_eq("rst_pipe_din", pipe_din, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_resp_valid", resp_valid, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Full contention from rr_ptr=0.
    for (int c = 0; c < 8; c++) step(1'b1, 4'b1111, rand_data());
    for (int c = 0; c < L + 2; c++) step(1'b1, 4'b0000, rand_data());

    // Single requester, operands 0x11 then 0x22.
    d = '0; d[2*W +: W] = 32'h11;
    step(1'b1, 4'b0100, d);
    d[2*W +: W] = 32'h22;
    step(1'b1, 4'b0100, d);
    for (int c = 0; c < L + 2; c++) step(1'b1, 4'b0000, rand_data());

    // Pointer fairness: 3 granted, then only 1 and 3 contend.
    step(1'b1, 4'b1000, rand_data());
    step(1'b1, 4'b1010, rand_data());
    step(1'b1, 4'b1010, rand_data());

    // Global disable with everyone requesting, then drain.
    for (int c = 0; c < 3; c++) step(1'b0, 4'b1111, rand_data());
    for (int c = 0; c < L + 2; c++) step(1'b0, 4'b0000, rand_data());

    for (int c = 0; c < 400; c++) begin
      step(($urandom % 8) != 0, N'($urandom), rand_data());
    end

    // Reset with operations in flight.
    for (int c = 0; c < 3; c++) step(1'b1, 4'b1111, rand_data());
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_resp_valid", resp_valid, '0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_pipe_issue", pipe_issue, 1'b0);
    model_reset();
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < L + 2; c++) step(1'b1, 4'b0000, rand_data());

    for (int c = 0; c < 300; c++) begin
      step(($urandom % 6) != 0, N'($urandom), rand_data());
    end
    for (int c = 0; c < L + 2; c++) step(1'b1, 4'b0000, rand_data());

`ifdef PIPE_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      check_eq("stat_grants", stat_grants[i*16 +: 16], (grants[i] > 65535) ? 16'hFFFF : 16'(grants[i]));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
